// File: rtl/rotate_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_arbiter_if
//  Description : Request/grant and result valid/ready bundle shared between
//                the rotate clients and the rotate_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

interface rotate_arbiter_if #(
   parameter int N = `DEFAULT_WIDTH,
   parameter int M = 4
);
   localparam int c_lw = $clog2(N);
   localparam int c_iw = $clog2(M);

   logic [M-1:0]      req;
   logic [M-1:0]      dir;
   logic [M*N-1:0]    a;
   logic [M*c_lw-1:0] b;
   logic [M-1:0]      gnt;
   logic [N-1:0]      out;
   logic [c_iw-1:0]   out_id;
   logic              out_valid;
   logic              out_ready;

   // Client side: presents operations and consumes results
   modport master (
      output req, dir, a, b, out_ready,
      input  gnt, out, out_id, out_valid
   );

   // Arbiter side: grants operations and produces results
   modport slave (
      input  req, dir, a, b, out_ready,
      output gnt, out, out_id, out_valid
   );
endinterface

`default_nettype wire

// File: rtl/rotate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_arbiter
//  Description : Round-robin arbiter sharing one log2-stage barrel rotator
//                between M requesters; result held in a valid/ready register
//                tagged with the winning requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module rotate_arbiter #(
   parameter int N = `DEFAULT_WIDTH,
   parameter int M = 4
) (
   input  wire logic        clk,
   input  wire logic        rst,
   rotate_arbiter_if.slave  bus
);
   localparam int c_lw = $clog2(N);
   localparam int c_iw = $clog2(M);

   logic [c_iw-1:0] r_ptr;
   logic [N-1:0]    r_out;
   logic [c_iw-1:0] r_out_id;
   logic            r_out_valid;

   logic            w_can_accept;
   logic            w_found;
   logic [c_iw-1:0] w_winner;
   logic [c_iw:0]   w_sum;
   logic [c_iw-1:0] w_cand;
   logic            w_grant;
   logic [M-1:0]    w_gnt;

   logic [N-1:0]    w_a_arr [M];
   logic [c_lw-1:0] w_b_arr [M];
   logic [N-1:0]    w_sel_a;
   logic [c_lw-1:0] w_sel_b;
   logic            w_sel_dir;
   logic [N-1:0]    w_stage [c_lw+1];

   // A new operation may enter whenever the result slot is empty or draining
   assign w_can_accept = !r_out_valid || bus.out_ready;

   // Round-robin search: first set request from r_ptr upward, wrapping at M
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_cand   = '0;
      for (int k = 0; k < M; k++) begin
         w_sum = {1'b0, r_ptr} + (c_iw+1)'(k);
         if (w_sum >= (c_iw+1)'(M)) begin
            w_sum = w_sum - (c_iw+1)'(M);
         end
         w_cand = w_sum[c_iw-1:0];
         if (!w_found && bus.req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // No grant during reset or while the output register is stalled
   assign w_grant = w_found && w_can_accept && !rst;
   assign w_gnt   = w_grant ? (M'(1) << w_winner) : '0;
   assign bus.gnt = w_gnt;

   // Unpack the per-requester operand fields for the winner mux
   for (genvar i = 0; i < M; i++) begin : g_unpack
      assign w_a_arr[i] = bus.a[i*N +: N];
      assign w_b_arr[i] = bus.b[i*c_lw +: c_lw];
   end

   assign w_sel_a   = w_a_arr[w_winner];
   assign w_sel_b   = w_b_arr[w_winner];
   assign w_sel_dir = bus.dir[w_winner];

   // Barrel rotator: stage s rotates by 2**s in the selected direction
   assign w_stage[0] = w_sel_a;
   for (genvar s = 0; s < c_lw; s++) begin : g_stage
      localparam int c_sh = 1 << s;
      assign w_stage[s+1] = !w_sel_b[s] ? w_stage[s] :
                            w_sel_dir   ? {w_stage[s][N-1-c_sh:0], w_stage[s][N-1:N-c_sh]} :
                                          {w_stage[s][c_sh-1:0], w_stage[s][N-1:c_sh]};
   end

   // Priority pointer moves past the winner on every grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         r_ptr <= (w_winner == c_iw'(M-1)) ? '0 : w_winner + 1'b1;
      end
   end

   // Result register: load on grant, drop valid when drained without refill
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_out_id    <= '0;
         r_out_valid <= 1'b0;
      end else if (w_grant) begin
         r_out       <= w_stage[c_lw];
         r_out_id    <= w_winner;
         r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out       = r_out;
   assign bus.out_id    = r_out_id;
   assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_rotate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rotate_arbiter
//  Description : Self-checking bench for rotate_arbiter (N=8, M=4) using a
//                result scoreboard fed at grant time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_arbiter;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rotate_arbiter_if #(.N(8), .M(4)) bus ();

   rotate_arbiter #(.N(8), .M(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         total = 0;
   int         bad   = 0;
   logic [9:0] sb_q[$];
   logic       m_valid;
   logic [7:0] m_out;
   logic [1:0] m_id;

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference rotate, bit by bit
   function automatic logic [7:0] rot(input logic [7:0] x, input logic [2:0] s, input logic d);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (d) r[(i + int'(s)) % 8]     = x[i];
         else   r[(i + 8 - int'(s)) % 8] = x[i];
      end
      return r;
   endfunction

   task automatic set_lane(input int i, input logic [7:0] av, input logic [2:0] bv, input logic dv);
      bus.a[i*8 +: 8] = av;
      bus.b[i*3 +: 3] = bv;
      bus.dir[i]      = dv;
   endtask

   // One clock: check gnt mid-cycle, push expected result, then check outputs
   task automatic cycle(input string tag, input logic [3:0] exp_gnt);
      logic [9:0] e;
      int lane;
      @(negedge clk);
      check({tag, " gnt"}, 32'(bus.gnt), 32'(exp_gnt));
      if (exp_gnt != 4'b0000) begin
         lane = 0;
         for (int i = 0; i < 4; i++) if (exp_gnt[i]) lane = i;
         sb_q.push_back({2'(lane), rot(bus.a[lane*8 +: 8], bus.b[lane*3 +: 3], bus.dir[lane])});
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 1'b0;
         m_out   = '0;
         m_id    = '0;
      end else if (exp_gnt != 4'b0000) begin
         check({tag, " sb_depth"}, 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            m_out   = e[7:0];
            m_id    = e[9:8];
            m_valid = 1'b1;
         end
      end else if (bus.out_ready) begin
         m_valid = 1'b0;
      end
      check({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_valid));
      check({tag, " out"},       32'(bus.out),       32'(m_out));
      check({tag, " out_id"},    32'(bus.out_id),    32'(m_id));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_valid       = 1'b0;
      m_out         = '0;
      m_id          = '0;
      rst           = 1'b1;
      bus.req       = 4'b1111;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.dir       = '0;
      for (int i = 0; i < 4; i++) set_lane(i, 8'h81, 3'd1, 1'b1);

      // Reset with all requests high: no grant, outputs cleared
      cycle("rst0", 4'b0000);
      cycle("rst1", 4'b0000);
      rst = 1'b0;

      // Round-robin over all four lanes, 81 rotl 1 = 03
      cycle("rr0", 4'b0001);
      cycle("rr1", 4'b0010);
      cycle("rr2", 4'b0100);
      cycle("rr3", 4'b1000);
      cycle("rr4", 4'b0001);
      check("rr_value", 32'(bus.out), 32'h03);

      // Single requester, left then right
      bus.req = 4'b0010;
      set_lane(1, 8'b10000111, 3'd3, 1'b1);
      cycle("left", 4'b0010);
      check("left_value", 32'(bus.out), 32'h3C);
      set_lane(1, 8'b10000111, 3'd3, 1'b0);
      cycle("right", 4'b0010);
      check("right_value", 32'(bus.out), 32'hF0);

      // Backpressure: result held, no grant while stalled
      bus.out_ready = 1'b0;
      bus.req       = 4'b0100;
      set_lane(2, 8'hA5, 3'd0, 1'b1);
      for (int i = 0; i < 3; i++) cycle("stall", 4'b0000);
      bus.out_ready = 1'b1;
      cycle("unstall", 4'b0100);

      // Boundary amounts, back-to-back results
      set_lane(2, 8'hA5, 3'd0, 1'b0);
      cycle("b0_right", 4'b0100);
      check("b0_value", 32'(bus.out), 32'hA5);
      set_lane(2, 8'h01, 3'd7, 1'b0);
      cycle("b7_right", 4'b0100);
      check("b7r_value", 32'(bus.out), 32'h02);
      set_lane(2, 8'h01, 3'd7, 1'b1);
      cycle("b7_left", 4'b0100);
      check("b7l_value", 32'(bus.out), 32'h80);

      // Reset mid-stream with a stalled valid result
      bus.out_ready = 1'b0;
      bus.req       = 4'b0000;
      cycle("hold", 4'b0000);
      bus.req = 4'b1010;
      set_lane(1, 8'h0F, 3'd2, 1'b1);
      set_lane(3, 8'hC3, 3'd4, 1'b0);
      rst = 1'b1;
      cycle("mid_rst", 4'b0000);
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      cycle("post_rst", 4'b0010);
      cycle("post_next", 4'b1000);
      bus.req = 4'b0000;
      cycle("drain", 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
